// File: rtl/la_ioringctrl.sv
`default_nettype none
// ============================================================================
// Module      : la_ioringctrl
// Description : Power-up/power-down sequencer for the generic ioring control
//               bus. It synchronizes the IO-supply power-good flag, holds
//               isolation for a settle period, and then releases the ring
//               segments one at a time in a thermometer order. On disable it
//               ramps them down in reverse order. A loss of power-good drops
//               the ring immediately.
//               Optional: define LA_IORINGCTRL_WDOG_EN to add a watchdog on
//               the power-good wait, which drives a sticky fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module la_ioringctrl #(
    parameter int RINGW   = 8,
    parameter int CW      = 8,
    parameter int SETTLE  = 16,
    parameter int STEP    = 4,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwrgood,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             busy,
    output logic             fault
);

    localparam int            IW          = (RINGW > 1) ? $clog2(RINGW) : 1;
    localparam logic [CW-1:0] c_settle_m1 = CW'(SETTLE - 1);
    localparam logic [CW-1:0] c_step_m1   = CW'(STEP - 1);
    localparam logic [IW-1:0] c_idx_last  = IW'(RINGW - 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_WAIT_PG = 3'd1,
        S_ISO     = 3'd2,
        S_UP      = 3'd3,
        S_ON      = 3'd4,
        S_DOWN    = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_pg_meta;
    logic             r_pg_s;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [RINGW-1:0] r_ioring;
    logic             r_ready;
    logic             r_busy;

    logic             w_active;
    logic             w_pg_lost;
    logic             w_ramp_down;
    logic             w_fault_hold;

`ifdef LA_IORINGCTRL_WDOG_EN
    localparam logic [CW-1:0] c_timeout_m1 = CW'(TIMEOUT - 1);
    logic [CW-1:0]    r_wdog;
    logic             r_fault;
    assign w_fault_hold = r_fault;
    assign fault        = r_fault;
`else
    assign w_fault_hold = 1'b0;
    assign fault        = 1'b0;
`endif

    // States in which the ring may be (partly) powered and brownout applies
    assign w_active    = (r_state == S_ISO) || (r_state == S_UP) ||
                         (r_state == S_ON)  || (r_state == S_DOWN);
    assign w_pg_lost   = w_active && !r_pg_s;
    // One ramp-down step: the entry step from ISO/UP/ON, or a timed DOWN step.
    // Both clear the highest set bit, so they share one code path.
    assign w_ramp_down = (!en && ((r_state == S_ISO) || (r_state == S_UP) ||
                                  (r_state == S_ON))) ||
                         ((r_state == S_DOWN) && (r_cnt == '0));

    assign ioring = r_ioring;
    assign ready  = r_ready;
    assign busy   = r_busy;

    // Power-good synchronizer plus the sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pg_meta <= 1'b0;
            r_pg_s    <= 1'b0;
            r_state   <= S_OFF;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ioring  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef LA_IORINGCTRL_WDOG_EN
            r_wdog    <= '0;
            r_fault   <= 1'b0;
`endif
        end else begin
            r_pg_meta <= pwrgood;
            r_pg_s    <= r_pg_meta;

            if (w_pg_lost) begin
                // Brownout: drop the whole ring at once, not a fault
                r_ioring <= '0;
                r_ready  <= 1'b0;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_idx    <= '0;
                r_state  <= en ? S_WAIT_PG : S_OFF;
`ifdef LA_IORINGCTRL_WDOG_EN
                r_wdog   <= '0;
`endif
            end else if (w_ramp_down) begin
                // Thermometer code: clearing the top set bit is a right shift
                r_ioring <= r_ioring >> 1;
                r_ready  <= 1'b0;
                r_cnt    <= c_step_m1;
                if (!r_ioring[1]) begin
                    // Bit 0 (or nothing) was the last one set: ramp finished
                    r_state <= S_OFF;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end else begin
                    r_state <= S_DOWN;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_OFF: begin
`ifdef LA_IORINGCTRL_WDOG_EN
                        if (!en) begin
                            r_fault <= 1'b0;
                        end
`endif
                        // A pending fault keeps us here until en is seen low
                        if (en && !w_fault_hold) begin
                            r_state <= S_WAIT_PG;
`ifdef LA_IORINGCTRL_WDOG_EN
                            r_wdog  <= '0;
`endif
                        end
                    end
                    S_WAIT_PG: begin
                        if (!en) begin
                            r_state <= S_OFF;
`ifdef LA_IORINGCTRL_WDOG_EN
                            r_fault <= 1'b0;
`endif
                        end else if (r_pg_s) begin
                            r_state <= S_ISO;
                            r_cnt   <= c_settle_m1;
                            r_busy  <= 1'b1;
                        end
`ifdef LA_IORINGCTRL_WDOG_EN
                        else if (r_wdog == c_timeout_m1) begin
                            r_fault <= 1'b1;
                            r_state <= S_OFF;
                        end else begin
                            r_wdog  <= r_wdog + 1'b1;
                        end
`endif
                    end
                    S_ISO: begin
                        if (r_cnt == '0) begin
                            r_ioring <= {{(RINGW-1){1'b0}}, 1'b1};
                            r_idx    <= IW'(1);
                            r_cnt    <= c_step_m1;
                            r_state  <= S_UP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_UP: begin
                        if (r_cnt == '0) begin
                            r_ioring <= {r_ioring[RINGW-2:0], 1'b1};
                            if (r_idx == c_idx_last) begin
                                r_state <= S_ON;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                                r_cnt <= c_step_m1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_ON: begin
                        r_ready <= 1'b1;
                    end
                    S_DOWN: begin
                        // Only reached with a non-zero count; zero is a ramp step
                        r_cnt <= r_cnt - 1'b1;
                    end
                    default: begin
                        r_state  <= S_OFF;
                        r_ioring <= '0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_ioringctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_ioringctrl
// Description : Self-checking bench for la_ioringctrl. A phase/level model of
//               the sequencer predicts the ring every cycle under directed
//               and random en/pwrgood stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_ioringctrl;

    localparam int RINGW   = 8;
    localparam int CW      = 8;
    localparam int SETTLE  = 16;
    localparam int STEP    = 4;
    localparam int TIMEOUT = 200;
`ifdef LA_IORINGCTRL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    localparam int P_OFF = 0, P_WAIT = 1, P_ISO = 2, P_UP = 3, P_ON = 4, P_DOWN = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             pwrgood;
    logic [RINGW-1:0] ioring;
    logic             ready;
    logic             busy;
    logic             fault;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase, number of segments lit, cycles to next change, watchdog
    int m_ph;
    int m_lvl;
    int m_wait;
    int m_wd;
    bit m_fault;
    bit m_p1;
    bit m_p2;

    la_ioringctrl #(
        .RINGW(RINGW), .CW(CW), .SETTLE(SETTLE), .STEP(STEP), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .pwrgood(pwrgood),
        .ioring(ioring), .ready(ready), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_OFF; m_lvl = 0; m_wait = 0; m_wd = 0;
        m_fault = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
    endtask

    // One clock of the spec's rules, using the pre-edge inputs
    task automatic model_step(input bit e);
        bit pg;
        pg = m_p2;
        if ((m_ph == P_ISO || m_ph == P_UP || m_ph == P_ON || m_ph == P_DOWN) && !pg) begin
            m_lvl = 0;
            m_ph  = e ? P_WAIT : P_OFF;
            m_wd  = 0;
        end else begin
            case (m_ph)
                P_OFF: begin
                    if (!e) m_fault = 1'b0;
                    else if (!m_fault) begin m_ph = P_WAIT; m_wd = 0; end
                end
                P_WAIT: begin
                    if (!e) begin m_ph = P_OFF; m_fault = 1'b0; end
                    else if (pg) begin m_ph = P_ISO; m_wait = SETTLE; end
                    else if (WDOG && m_wd == TIMEOUT - 1) begin m_fault = 1'b1; m_ph = P_OFF; end
                    else m_wd++;
                end
                P_ISO, P_UP, P_ON: begin
                    if (!e) begin
                        m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                        if (m_lvl == 0) m_ph = P_OFF;
                        else begin m_ph = P_DOWN; m_wait = STEP; end
                    end else if (m_ph != P_ON) begin
                        m_wait--;
                        if (m_wait == 0) begin
                            m_lvl++;
                            if (m_lvl == RINGW) m_ph = P_ON;
                            else begin m_ph = P_UP; m_wait = STEP; end
                        end
                    end
                end
                default: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_lvl--;
                        if (m_lvl == 0) m_ph = P_OFF;
                        else m_wait = STEP;
                    end
                end
            endcase
        end
        m_p2 = m_p1;
        m_p1 = pwrgood;
    endtask

    task automatic tick(input logic e, input logic p);
        logic [31:0] exp_ring;
        en = e;
        pwrgood = p;
        @(posedge clk);
        model_step(e);
        @(negedge clk);
        exp_ring = (32'd1 << m_lvl) - 32'd1;
        chk("ioring", 32'(ioring), exp_ring);
        chk("ready", 32'(ready), 32'(m_ph == P_ON));
        chk("busy", 32'(busy), 32'(m_ph == P_ISO || m_ph == P_UP || m_ph == P_DOWN));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    // Drive constant inputs until the ring shows a target code, bounded
    task automatic wait_ring(input string tag, input logic e, input logic p, input logic [RINGW-1:0] tgt);
        for (int i = 0; i < 400 && ioring !== tgt; i++) tick(e, p);
        chk(tag, 32'(ioring), 32'(tgt));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; en = 1'b0; pwrgood = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ioring", 32'(ioring), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        // Power-up from reset: bit 0 on the 19th edge after en, full at 47
        repeat (18) tick(1'b1, 1'b1);
        chk("rel_before", 32'(ioring[0]), 32'd0);
        tick(1'b1, 1'b1);
        chk("rel_at_19", 32'(ioring[0]), 32'd1);
        repeat (28) tick(1'b1, 1'b1);
        chk("full_on", 32'(ioring), 32'hFF);
        chk("ready_on", 32'(ready), 32'd1);

        // Disable from ON: immediate first step, then every STEP
        tick(1'b0, 1'b1);
        chk("first_down", 32'(ioring), 32'h7F);
        repeat (28) tick(1'b0, 1'b1);
        chk("down_done", 32'(ioring), 32'h00);

        // Brownout in UP at 0x0F, then recovery
        wait_ring("reach_0f", 1'b1, 1'b1, 8'h0F);
        repeat (3) tick(1'b1, 1'b0);
        chk("brownout", 32'(ioring), 32'h00);
        wait_ring("recover_ff", 1'b1, 1'b1, 8'hFF);

        // Re-enable during the ramp-down at 0x3F: ramp completes, then restart
        wait_ring("reach_3f", 1'b0, 1'b1, 8'h3F);
        repeat (80) tick(1'b1, 1'b1);

        // Asynchronous reset in UP at 0x07, checked between clock edges
        wait_ring("drain", 1'b0, 1'b1, 8'h00);
        wait_ring("reach_07", 1'b1, 1'b1, 8'h07);
        #2 reset = 1'b1;
        #1;
        chk("arst_ioring", 32'(ioring), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Long power-good absence: watchdog behaviour if built in
        repeat (260) tick(1'b1, 1'b0);
        chk("wdog_fault", 32'(fault), 32'(WDOG));
        repeat (5) tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b0);
        chk("fault_clr", 32'(fault), 32'd0);
        repeat (30) tick(1'b1, 1'b1);

        // Random segments of held inputs
        for (int s = 0; s < 200; s++) begin
            logic e, p;
            int len;
            e   = ($urandom % 4) != 0;
            p   = ($urandom % 5) != 0;
            len = $urandom_range(1, 70);
            if (($urandom % 25) == 0) len = 230;
            repeat (len) tick(e, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
